// File: rtl/aig_bist_pkg.sv
// Shared types and defaults for the AIG BIST driver and its MISR.
package aig_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam logic [15:0] MISR_POLY_DEFAULT = 16'h1021;

endpackage

// File: rtl/aig_misr.sv
// Multiple-input signature register: shift left, fold the MSB back through
// the tap polynomial, then xor in the parallel response word.
module aig_misr
  import aig_bist_pkg::*;
#(
  parameter int               N_OUT     = 16,
  parameter logic [N_OUT-1:0] MISR_POLY = N_OUT'(MISR_POLY_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [N_OUT-1:0] seed,
  input  logic             en,
  input  logic [N_OUT-1:0] d,
  output logic [N_OUT-1:0] q
);

  logic [N_OUT-1:0] q_q, q_d;

  // NOTE: assign the default first so every path writes q_d and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (en) begin
      q_d = {q_q[N_OUT-2:0], 1'b0} ^ (q_q[N_OUT-1] ? MISR_POLY : '0) ^ d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/aig_bist_driver.sv
// Exhaustive stimulus driver for a combinational AIG circuit: walks every
// input vector, compacts the responses in a MISR and compares to a golden value.
module aig_bist_driver
  import aig_bist_pkg::*;
#(
  parameter int               N_IN      = 6,
  parameter int               N_OUT     = 16,
  parameter int               SETTLE    = 1,
  parameter logic [N_OUT-1:0] MISR_POLY = N_OUT'(MISR_POLY_DEFAULT),
  parameter logic [N_OUT-1:0] MISR_SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] golden,
  output logic [N_IN-1:0]  dut_x,
  input  logic [N_OUT-1:0] dut_f,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] signature,
  output logic             pass
);

  localparam int              SW         = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0]   SETTLE_END = SW'(SETTLE);
  // One spare bit so the last-vector compare can never alias a wrapped count.
  localparam logic [N_IN:0]   LAST_VEC   = {1'b0, {N_IN{1'b1}}};

  state_e           state_q, state_d;
  logic [N_IN:0]    vec_q, vec_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [N_OUT-1:0] sig_q, sig_d;
  logic             pass_q, pass_d;
  logic             misr_load, misr_en;
  logic [N_OUT-1:0] misr_q;

  aig_misr #(
    .N_OUT     (N_OUT),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (misr_load),
    .seed (MISR_SEED),
    .en   (misr_en),
    .d    (dut_f),
    .q    (misr_q)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    sig_d     = sig_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_APPLY;
          vec_d     = '0;
          settle_d  = '0;
          misr_load = 1'b1;
        end
      end
      ST_APPLY: begin
        if (abort)                       state_d  = ST_IDLE;
        else if (settle_q == SETTLE_END) state_d  = ST_CAPTURE;
        else                             settle_d = settle_q + 1'b1;
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          misr_en = 1'b1;
          if (vec_q == LAST_VEC) begin
            state_d = ST_DONE;
          end else begin
            vec_d    = vec_q + 1'b1;
            settle_d = '0;
            state_d  = ST_APPLY;
          end
        end
      end
      ST_DONE: begin
        sig_d   = misr_q;
        pass_d  = (misr_q == golden);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      sig_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      sig_q    <= sig_d;
      pass_q   <= pass_d;
    end
  end

  // The DONE cycle shows the fresh result; pass reads low while a run is in flight.
  assign dut_x     = vec_q[N_IN-1:0];
  assign busy      = (state_q == ST_APPLY) || (state_q == ST_CAPTURE);
  assign done      = (state_q == ST_DONE);
  assign signature = done ? misr_q : sig_q;
  assign pass      = done ? (misr_q == golden) : ((state_q == ST_IDLE) && pass_q);

endmodule

// File: tb/tb_aig_bist_driver.sv
// Scoreboard bench for aig_bist_driver: a small 2-in/4-out instance and a default instance.
module tb_aig_bist_driver;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] golden;
  int          sel, fmode;

  always #5 clk = ~clk;

  logic       s_start, s_abort, s_busy, s_done, s_pass;
  logic [1:0] s_x;
  logic [3:0] s_f, s_sig;
  logic        d_start, d_abort, d_busy, d_done, d_pass;
  logic [5:0]  d_x;
  logic [15:0] d_f, d_sig;

  assign s_start = start && (sel == 0);
  assign s_abort = abort && (sel == 0);
  assign d_start = start && (sel == 1);
  assign d_abort = abort && (sel == 1);
  assign s_f     = (fmode == 0) ? 4'h1 : {2'b00, s_x};
  assign d_f     = (fmode == 0) ? 16'h0000 : {~d_x, 4'hA, d_x};

  aig_bist_driver #(
    .N_IN (2), .N_OUT (4), .SETTLE (0), .MISR_POLY (4'h3), .MISR_SEED (4'h0)
  ) u_small (
    .clk (clk), .rst (rst), .start (s_start), .abort (s_abort), .golden (golden[3:0]),
    .dut_x (s_x), .dut_f (s_f), .busy (s_busy), .done (s_done),
    .signature (s_sig), .pass (s_pass)
  );

  aig_bist_driver u_dflt (
    .clk (clk), .rst (rst), .start (d_start), .abort (d_abort), .golden (golden),
    .dut_x (d_x), .dut_f (d_f), .busy (d_busy), .done (d_done),
    .signature (d_sig), .pass (d_pass)
  );

  logic        m_busy, m_done, m_pass;
  logic [5:0]  m_x;
  logic [15:0] m_sig;

  always_comb begin
    if (sel == 0) begin
      m_busy = s_busy; m_done = s_done; m_pass = s_pass;
      m_x    = {4'b0, s_x};
      m_sig  = {12'b0, s_sig};
    end else begin
      m_busy = d_busy; m_done = d_done; m_pass = d_pass;
      m_x    = d_x;
      m_sig  = d_sig;
    end
  end

  typedef struct {
    int          cycles;
    logic [15:0] sig;
    logic        pass;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] d_last_sig  = '0;
  logic        d_last_pass = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Signature of an exhaustive run, straight from the MISR recurrence.
  function automatic logic [15:0] model_sig(input int s, input int fm);
    int          n_in  = (s == 0) ? 2 : 6;
    int          n_out = (s == 0) ? 4 : 16;
    logic [15:0] poly  = (s == 0) ? 16'h0003 : 16'h1021;
    logic [15:0] mask  = (s == 0) ? 16'h000F : 16'hFFFF;
    logic [15:0] sig   = '0;
    logic [15:0] f;
    logic [5:0]  v;
    for (int i = 0; i < (1 << n_in); i++) begin
      v = 6'(i);
      if (s == 0) f = (fm == 0) ? 16'h0001 : {10'b0, v};
      else        f = (fm == 0) ? 16'h0000 : {~v, 4'hA, v};
      sig = ((sig << 1) & mask) ^ (sig[n_out-1] ? poly : 16'h0000) ^ f;
    end
    return sig;
  endfunction

  task automatic run(input logic [15:0] gold, input bit hold_start, input bit with_abort);
    exp_t e;
    int   per, cyc, xbad;
    bit   seen;
    per      = (sel == 0) ? 2 : 3;
    e.cycles = ((sel == 0) ? 4 : 64) * per;
    e.sig    = model_sig(sel, fmode);
    e.pass   = (e.sig == gold);
    sb.push_back(e);
    @(negedge clk);
    golden = gold;
    start  = 1'b1;
    abort  = with_abort;
    @(negedge clk);
    abort = 1'b0;
    if (!hold_start) start = 1'b0;
    check("busy_rise", m_busy, 1);
    check("x_first", m_x, 0);
    check("pass_in_run", m_pass, 0);
    cyc = 0; xbad = 0; seen = 0;
    while (cyc < 1000 && !seen) begin
      @(negedge clk);
      cyc++;
      if (m_done) seen = 1;
      else if (m_x != 6'(cyc / per)) xbad++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check("x_sequence_errs", xbad, 0);
    check("done_cycles", cyc, e.cycles);
    check("busy_at_done", m_busy, 0);
    check("signature", m_sig, e.sig);
    check("pass", m_pass, e.pass);
    if (sel == 1) begin
      d_last_sig  = e.sig;
      d_last_pass = e.pass;
    end
  endtask

  task automatic run_abort(input int at_vec);
    int dcount = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (at_vec * 3) @(negedge clk);
    check("x_at_abort", m_x, at_vec);
    start = 1'b1;
    @(negedge clk);
    check("start_ignored_busy", m_busy, 1);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("busy_after_abort", m_busy, 0);
    repeat (300) begin
      @(negedge clk);
      if (m_done) dcount++;
    end
    check("no_done_after_abort", dcount, 0);
    check("sig_kept_abort", m_sig, d_last_sig);
    check("pass_kept_abort", m_pass, d_last_pass);
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("x_before_rst", m_x, 10);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", m_busy, 0);
    check("rst_x", m_x, 0);
    check("rst_sig", m_sig, 0);
    check("rst_pass", m_pass, 0);
    @(negedge clk);
    rst = 1'b0;
    d_last_sig  = '0;
    d_last_pass = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; golden = '0; sel = 0; fmode = 0;
    repeat (3) @(negedge clk);
    check("reset_s_busy", s_busy, 0);
    check("reset_s_done", s_done, 0);
    check("reset_s_x", s_x, 0);
    check("reset_s_sig", s_sig, 0);
    check("reset_d_busy", d_busy, 0);
    check("reset_d_x", d_x, 0);
    check("reset_d_sig", d_sig, 0);
    check("reset_d_pass", d_pass, 0);
    rst = 1'b0;

    sel = 0; fmode = 0;
    run(16'h0000, 0, 0);
    fmode = 1;
    run(16'h0003, 0, 0);
    run(16'h0002, 0, 1);
    @(negedge clk);
    check("done_one_cycle", m_done, 0);
    check("sig_hold", m_sig, 16'h0003);
    check("pass_hold", m_pass, 0);

    sel = 1; fmode = 0;
    run(16'h0000, 0, 0);
    run(16'h0000, 0, 0);
    fmode = 1;
    run(model_sig(1, 1), 1, 0);
    run_abort(5);
    reset_mid_run();
    fmode = 0;
    run(16'h0001, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
